expr_editor: RTL and testbench

//  Line editor for the function-expression string. Consumes the one-cycle key events
//  (left, right, backspace, 7-bit ASCII symbol) decoded from the PS/2 keyboard.

---
 rtl/expr_editor_pkg.sv | 7 +
 rtl/expr_editor_if.sv | 29 ++
 rtl/expr_editor_cursor_blink.sv | 30 +++
 rtl/expr_editor.sv | 96 +++++++++
 tb/tb_expr_editor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/expr_editor_pkg.sv
// Shared character width and expression capacity. The renderer and the parser
// import the same definitions so that all three agree on them.
package function_plotter_pkg;
  localparam int CHAR_W       = 7;
  localparam int EXPR_MAX_LEN = 32;
  typedef logic [CHAR_W-1:0] char_t;
endpackage

// File: rtl/expr_editor_if.sv
// Key-event, read-port and status bundle between the keyboard/renderer side
// (master) and the expression editor (slave).
interface expr_editor_if import function_plotter_pkg::*; #(
  parameter int MAX_LEN = EXPR_MAX_LEN
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          left;
  logic          right;
  logic          backspace;
  char_t         symbol;
  logic [AW-1:0] rd_addr;
  char_t         rd_char;
  logic [LW-1:0] length;
  logic [LW-1:0] cursor;
  logic          changed;
  logic          cursor_visible;

  modport master (
    output left, right, backspace, symbol, rd_addr,
    input  rd_char, length, cursor, changed, cursor_visible
  );

  modport slave (
    input  left, right, backspace, symbol, rd_addr,
    output rd_char, length, cursor, changed, cursor_visible
  );
endinterface

// File: rtl/expr_editor_cursor_blink.sv
// Cursor blink phase: a down-counter reloads at terminal count and toggles the
// phase. A restart pulse forces the cursor visible and restarts a full half-period.
module cursor_blink #(
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic visible
);
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= RELOAD;
      visible <= 1'b1;
    end else if (restart) begin
      cnt     <= RELOAD;
      visible <= 1'b1;
    end else if (cnt == '0) begin
      cnt     <= RELOAD;
      visible <= ~visible;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/expr_editor.sv
// Single-line editor for the function expression: flop buffer with insertion cursor.
// Optional cursor blinking is built in when EXPR_EDITOR_BLINK_EN is defined.
module expr_editor import function_plotter_pkg::*; #(
  parameter int MAX_LEN      = EXPR_MAX_LEN,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic          clk,
  input  logic          rst_n,
  expr_editor_if.slave  bus
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  if (MAX_LEN < 2 || MAX_LEN > 255 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("expr_editor: parameter out of range");
  end

  char_t         text_q [MAX_LEN];
  char_t         text_d [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [LW-1:0] cur_q;
  char_t         rd_q;
  logic          changed_q;
  logic          bs_ok, left_ok, right_ok, ins_ok;
  int            cur_i, len_i;
  logic [AW-1:0] cur_idx, last_idx;

  assign cur_i    = int'(cur_q);
  assign len_i    = int'(len_q);
  assign cur_idx  = cur_q[AW-1:0];
  assign last_idx = AW'(len_q - LW'(1));

  // Only the highest-priority pending key is considered; the others are dropped.
  assign bs_ok    = bus.backspace && (cur_q != '0);
  assign left_ok  = !bus.backspace && bus.left && (cur_q != '0);
  assign right_ok = !bus.backspace && !bus.left && bus.right && (cur_q < len_q);
  assign ins_ok   = !bus.backspace && !bus.left && !bus.right &&
                    (bus.symbol != '0) && (len_i < MAX_LEN);

  always_comb begin
    text_d = text_q;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (ins_ok && i > cur_i && i <= len_i) text_d[i] = text_q[i-1];
    end
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if (bs_ok && i >= cur_i - 1 && i < len_i - 1) text_d[i] = text_q[i+1];
    end
    if (ins_ok) text_d[cur_idx] = bus.symbol;
    // Vacated tail slot is zeroed so everything past length reads as 0.
    if (bs_ok) text_d[last_idx] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_q    <= '{default: '0};
      len_q     <= '0;
      cur_q     <= '0;
      rd_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      text_q    <= text_d;
      changed_q <= ins_ok | bs_ok;
      rd_q      <= (int'(bus.rd_addr) < len_i) ? text_q[bus.rd_addr] : '0;
      if (bs_ok) begin
        len_q <= len_q - LW'(1);
        cur_q <= cur_q - LW'(1);
      end else if (ins_ok) begin
        len_q <= len_q + LW'(1);
        cur_q <= cur_q + LW'(1);
      end else if (left_ok) begin
        cur_q <= cur_q - LW'(1);
      end else if (right_ok) begin
        cur_q <= cur_q + LW'(1);
      end
    end
  end

  assign bus.length  = len_q;
  assign bus.cursor  = cur_q;
  assign bus.rd_char = rd_q;
  assign bus.changed = changed_q;

`ifdef EXPR_EDITOR_BLINK_EN
  logic evt_ok;
  assign evt_ok = bs_ok | ins_ok | left_ok | right_ok;

  cursor_blink #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (evt_ok),
    .visible (bus.cursor_visible)
  );
`else
  assign bus.cursor_visible = 1'b1;
`endif
endmodule

// File: tb/tb_expr_editor.sv
// Directed bench for expr_editor: insert, cursor moves, backspace, full/empty
// edges, event priority, async reset and (when enabled) cursor blinking.
module tb_expr_editor;
  localparam int MAX_LEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  expr_editor_if #(.MAX_LEN(MAX_LEN)) bus ();

  expr_editor #(.MAX_LEN(MAX_LEN), .BLINK_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.left      = 1'b0;
    bus.right     = 1'b0;
    bus.backspace = 1'b0;
    bus.symbol    = '0;
  endtask

  // Drive one cycle of key events, then sample 1 time unit after the edge.
  task automatic key(input logic l, input logic r, input logic b, input byte sym);
    bus.left      = l;
    bus.right     = r;
    bus.backspace = b;
    bus.symbol    = sym[6:0];
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input int addr, input byte exp);
    bus.rd_addr = 5'(addr);
    @(posedge clk);
    #1;
    chk(tag, 32'(bus.rd_char), 32'(exp));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    bus.rd_addr = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_len",     32'(bus.length), 0);
    chk("rst_cur",     32'(bus.cursor), 0);
    chk("rst_rd",      32'(bus.rd_char), 0);
    chk("rst_changed", 32'(bus.changed), 0);
    chk("rst_vis",     32'(bus.cursor_visible), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: "sin"
    key(0, 0, 0, "s"); chk("t1_chg_s", 32'(bus.changed), 1);
    key(0, 0, 0, "i"); chk("t1_chg_i", 32'(bus.changed), 1);
    key(0, 0, 0, "n"); chk("t1_chg_n", 32'(bus.changed), 1);
    chk("t1_len", 32'(bus.length), 3);
    chk("t1_cur", 32'(bus.cursor), 3);
    read_chk("t1_rd0", 0, "s");
    chk("t1_chg_idle", 32'(bus.changed), 0);
    read_chk("t1_rd1", 1, "i");
    read_chk("t1_rd2", 2, "n");
    read_chk("t1_rd3", 3, 0);

    // 2: "x2", left, "^" -> "x^2"; backspace -> "x2"
    do_reset();
    key(0, 0, 0, "x");
    key(0, 0, 0, "2");
    key(1, 0, 0, 0);
    chk("t2_left_chg", 32'(bus.changed), 0);
    chk("t2_left_cur", 32'(bus.cursor), 1);
    key(0, 0, 0, "^");
    chk("t2_ins_chg", 32'(bus.changed), 1);
    chk("t2_ins_cur", 32'(bus.cursor), 2);
    chk("t2_ins_len", 32'(bus.length), 3);
    read_chk("t2_rd0", 0, "x");
    read_chk("t2_rd1", 1, "^");
    read_chk("t2_rd2", 2, "2");
    key(0, 0, 1, 0);
    chk("t2_bs_chg", 32'(bus.changed), 1);
    chk("t2_bs_cur", 32'(bus.cursor), 1);
    chk("t2_bs_len", 32'(bus.length), 2);
    read_chk("t2_bs_rd0", 0, "x");
    read_chk("t2_bs_rd1", 1, "2");
    read_chk("t2_bs_rd2", 2, 0);

    // 3: fill to capacity, then one more is ignored
    do_reset();
    for (int i = 0; i < MAX_LEN; i++) key(0, 0, 0, "1");
    chk("t3_full_len", 32'(bus.length), 32);
    key(0, 0, 0, "2");
    chk("t3_over_chg", 32'(bus.changed), 0);
    chk("t3_over_len", 32'(bus.length), 32);
    chk("t3_over_cur", 32'(bus.cursor), 32);
    read_chk("t3_rd31", 31, "1");
    read_chk("t3_rd0", 0, "1");

    // 4: empty-buffer no-ops, right at end of text
    do_reset();
    key(1, 0, 0, 0);
    chk("t4_left_chg", 32'(bus.changed), 0);
    chk("t4_left_cur", 32'(bus.cursor), 0);
    key(0, 0, 1, 0);
    chk("t4_bs_chg", 32'(bus.changed), 0);
    chk("t4_bs_len", 32'(bus.length), 0);
    chk("t4_bs_cur", 32'(bus.cursor), 0);
    key(0, 0, 0, "a");
    key(0, 1, 0, 0);
    chk("t4_right_chg", 32'(bus.changed), 0);
    chk("t4_right_cur", 32'(bus.cursor), 1);
    chk("t4_right_len", 32'(bus.length), 1);

    // 5: backspace beats symbol in the same cycle; then async reset mid-edit
    do_reset();
    key(0, 0, 0, "a");
    key(0, 0, 0, "b");
    key(0, 0, 1, "q");
    chk("t5_chg", 32'(bus.changed), 1);
    chk("t5_len", 32'(bus.length), 1);
    chk("t5_cur", 32'(bus.cursor), 1);
    read_chk("t5_rd1", 1, 0);
    read_chk("t5_rd0", 0, "a");
    key(0, 0, 0, "z");
    chk("t5_pre_len", 32'(bus.length), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_len", 32'(bus.length), 0);
    chk("t5_arst_cur", 32'(bus.cursor), 0);
    chk("t5_arst_rd",  32'(bus.rd_char), 0);
    chk("t5_arst_chg", 32'(bus.changed), 0);
    chk("t5_arst_vis", 32'(bus.cursor_visible), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    read_chk("t5_post_rd0", 0, 0);
    chk("t5_post_len", 32'(bus.length), 0);

    // 6: blink phase (BLINK_CYCLES = 4)
    do_reset();
    key(0, 0, 0, "a");
`ifdef EXPR_EDITOR_BLINK_EN
    chk("t6_vis_evt", 32'(bus.cursor_visible), 1);
    idle(3); chk("t6_vis_3", 32'(bus.cursor_visible), 1);
    idle(1); chk("t6_vis_4", 32'(bus.cursor_visible), 0);
    key(1, 0, 0, 0);
    chk("t6_left_vis", 32'(bus.cursor_visible), 1);
    chk("t6_left_cur", 32'(bus.cursor), 0);
    idle(3); chk("t6_vis_r3", 32'(bus.cursor_visible), 1);
    idle(1); chk("t6_vis_r4", 32'(bus.cursor_visible), 0);
    idle(4); chk("t6_vis_r8", 32'(bus.cursor_visible), 1);
`else
    idle(5); chk("t6_vis_fixed_a", 32'(bus.cursor_visible), 1);
    idle(4); chk("t6_vis_fixed_b", 32'(bus.cursor_visible), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
